// File: rtl/md_unit_ctrl.sv
// Purpose: RV64 M-extension sequencer (registered multiply, radix-2 restoring divide) for the EX stage.
// Latency: special-case divide 1, multiply 2, W divide 34, 64-bit divide 66 cycles from accept to done_o.
// Backpressure: stall_o holds IF/ID/EX from the accept cycle until the cycle before done_o; no input handshake.
module md_unit_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [4:0]      alu_control_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_MULH   = 5'b10000;
    localparam logic [4:0] OP_MULHSU = 5'b10001;
    localparam logic [4:0] OP_MULHU  = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10011;
    localparam logic [4:0] OP_DIVU   = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10101;
    localparam logic [4:0] OP_REMU   = 5'b10110;
    localparam logic [4:0] OP_MULW   = 5'b10111;
    localparam logic [4:0] OP_DIVW   = 5'b11000;
    localparam logic [4:0] OP_DIVUW  = 5'b11001;
    localparam logic [4:0] OP_REMW   = 5'b11010;
    localparam logic [4:0] OP_REMUW  = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_t;

    // 32-bit word results are always returned sign-extended to XLEN.
    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    state_t            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              is_w_q, is_w_d;
    logic              is_rem_q, is_rem_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Decode of the incoming control code (only meaningful in IDLE).
    logic in_m, in_mul, in_w, in_sgn, in_rem;

    assign in_m   = (alu_control_i >= OP_MUL) && (alu_control_i <= OP_REMUW);
    assign in_mul = alu_control_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    assign in_w   = in_m && (alu_control_i >= OP_MULW);
    assign in_sgn = alu_control_i inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    assign in_rem = alu_control_i inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};

    // Divide operand preparation: width/sign extension, magnitudes and special cases.
    logic [XLEN-1:0] dvd_ext, dvs_ext, dvd_abs, dvs_abs, sp_raw, sp_res;
    logic            dvd_neg, dvs_neg, dvs_zero, div_ovf;

    // Operand conditioning for a divide accepted this cycle.
    always_comb begin
        dvd_ext = src_a_i;
        dvs_ext = src_b_i;
        if (in_w) begin
            dvd_ext = in_sgn ? sext_w(src_a_i[31:0]) : zext_w(src_a_i[31:0]);
            dvs_ext = in_sgn ? sext_w(src_b_i[31:0]) : zext_w(src_b_i[31:0]);
        end
        dvd_neg  = in_sgn & dvd_ext[XLEN-1];
        dvs_neg  = in_sgn & dvs_ext[XLEN-1];
        dvd_abs  = dvd_neg ? -dvd_ext : dvd_ext;
        dvs_abs  = dvs_neg ? -dvs_ext : dvs_ext;
        dvs_zero = (dvs_ext == '0);
        if (in_w) begin
            div_ovf = in_sgn && (src_a_i[31:0] == 32'h8000_0000) && (src_b_i[31:0] == 32'hFFFF_FFFF);
        end else begin
            div_ovf = in_sgn && (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
        end
        // Zero divisor: quotient all ones, remainder = dividend.
        // Overflow: quotient = dividend, remainder = 0.
        if (in_rem) begin
            sp_raw = dvs_zero ? dvd_ext : '0;
        end else begin
            sp_raw = dvs_zero ? '1 : dvd_ext;
        end
        sp_res = in_w ? sext_w(sp_raw[31:0]) : sp_raw;
    end

    // Multiplier: operands widened to 2*XLEN with the per-op signedness, low 2*XLEN of the product kept.
    logic              mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
    logic [XLEN-1:0]   mul_res;

    // Product and half selection from the latched operands.
    always_comb begin
        mul_a_sgn = (op_q == OP_MULH) || (op_q == OP_MULHSU);
        mul_b_sgn = (op_q == OP_MULH);
        mul_a_ext = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
        mul_b_ext = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
        prod      = mul_a_ext * mul_b_ext;
        if (op_q == OP_MUL) begin
            mul_res = prod[XLEN-1:0];
        end else if (op_q == OP_MULW) begin
            mul_res = sext_w(prod[31:0]);
        end else begin
            mul_res = prod[2*XLEN-1:XLEN];
        end
    end

    // One restoring-divide step: shift remainder:dividend left, trial-subtract the divisor.
    logic [XLEN:0]   rem_sh, rem_try;
    logic            q_bit;
    logic [6:0]      n_iter;

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign rem_try = rem_sh - {1'b0, dvs_q};
    assign q_bit   = ~rem_try[XLEN];
    assign n_iter  = is_w_q ? 7'd32 : 7'(XLEN);

    // Sign fix-up of the magnitude quotient/remainder and result selection.
    logic [XLEN-1:0] q_raw, q_fix, r_fix, fx_sel, fx_res;

    always_comb begin
        q_raw  = is_w_q ? zext_w(quo_q[31:0]) : quo_q;
        q_fix  = negq_q ? -q_raw : q_raw;
        r_fix  = negr_q ? -rem_q : rem_q;
        fx_sel = is_rem_q ? r_fix : q_fix;
        fx_res = is_w_q ? sext_w(fx_sel[31:0]) : fx_sel;
    end

    // Next-state and datapath update; flush overrides everything except reset.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        is_w_d   = is_w_q;
        is_rem_d = is_rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && in_m) begin
                    op_d     = alu_control_i;
                    a_d      = src_a_i;
                    b_d      = src_b_i;
                    is_w_d   = in_w;
                    is_rem_d = in_rem;
                    negq_d   = dvd_neg ^ dvs_neg;
                    negr_d   = dvd_neg;
                    rem_d    = '0;
                    // W dividends start in the upper half so 32 shifts consume them.
                    quo_d    = in_w ? {dvd_abs[31:0], {(XLEN-32){1'b0}}} : dvd_abs;
                    dvs_d    = dvs_abs;
                    cnt_d    = '0;
                    if (in_mul) begin
                        state_d = S_MUL;
                    end else if (dvs_zero || div_ovf) begin
                        result_d = sp_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = mul_res;
                state_d  = S_DONE;
            end
            S_DIV: begin
                rem_d = q_bit ? rem_try[XLEN-1:0] : rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], q_bit};
                cnt_d = cnt_q + 7'd1;
                if (cnt_d == n_iter) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                result_d = fx_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            is_w_q   <= 1'b0;
            is_rem_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            is_w_q   <= is_w_d;
            is_rem_q <= is_rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = ((state_q == S_IDLE) && start_i && in_m) ||
                      (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIXUP);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Purpose: self-checking bench for md_unit_ctrl using an expected-result scoreboard.
// Latency: checks done_o cycle against the accept cycle for every queued operation.
// Backpressure: checks stall_o every cycle an operation is in flight.
module tb_md_unit_ctrl;

    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_MULH   = 5'b10000;
    localparam logic [4:0] OP_MULHSU = 5'b10001;
    localparam logic [4:0] OP_MULHU  = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10011;
    localparam logic [4:0] OP_DIVU   = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10101;
    localparam logic [4:0] OP_REMU   = 5'b10110;
    localparam logic [4:0] OP_MULW   = 5'b10111;
    localparam logic [4:0] OP_DIVW   = 5'b11000;
    localparam logic [4:0] OP_DIVUW  = 5'b11001;
    localparam logic [4:0] OP_REMW   = 5'b11010;
    localparam logic [4:0] OP_REMUW  = 5'b11011;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [4:0]  alu_control_i;
    logic [63:0] src_a_i;
    logic [63:0] src_b_i;
    logic        stall_o;
    logic        done_o;
    logic [63:0] result_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] exp_q[$];
    int          cyc_q[$];
    logic [63:0] mon_exp;
    int          mon_cyc;

    md_unit_ctrl #(.XLEN(64)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .alu_control_i (alu_control_i),
        .src_a_i       (src_a_i),
        .src_b_i       (src_b_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .result_o      (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every done_o pops one expectation and checks value and arrival cycle.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done_o), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = cyc_q.pop_front();
                chk("result", result_o, mon_exp);
                chk("done_cycle", 64'(cyc), 64'(mon_cyc));
            end
        end
    end

    task automatic scramble_inputs();
        start_i       = 1'b0;
        alu_control_i = 5'($urandom_range(15, 27));
        src_a_i       = {$urandom, $urandom};
        src_b_i       = {$urandom, $urandom};
    endtask

    // Accept one op in the next cycle; inputs are scrambled right after accept.
    task automatic accept(input logic [4:0] code, input logic [63:0] a, input logic [63:0] b,
                          input bit push, input logic [63:0] exp, input int lat, output int tgt);
        @(posedge clk_i); #1;
        start_i       = 1'b1;
        alu_control_i = code;
        src_a_i       = a;
        src_b_i       = b;
        tgt           = cyc + lat;
        if (push) begin
            exp_q.push_back(exp);
            cyc_q.push_back(tgt);
        end
        @(negedge clk_i);
        chk("stall_accept", 64'(stall_o), 64'd1);
        @(posedge clk_i); #1;
        scramble_inputs();
    endtask

    task automatic run(input logic [4:0] code, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
        int tgt;
        int k;
        accept(code, a, b, 1'b1, exp, lat, tgt);
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk_i);
            chk("stall_busy", 64'(stall_o), (cyc < tgt) ? 64'd1 : 64'd0);
            #1;
            k++;
            if (exp_q.size() != 0) begin
                @(posedge clk_i); #1;
            end
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    initial begin
        logic [63:0]        a, b;
        logic signed [63:0] sa, sb;
        logic [127:0]       p;
        int                 tgt;

        rst_i         = 1'b1;
        start_i       = 1'b0;
        flush_i       = 1'b0;
        alu_control_i = 5'd0;
        src_a_i       = '0;
        src_b_i       = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_stall", 64'(stall_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_result", result_o, 64'd0);

        // Directed cases, back-to-back.
        run(OP_MUL,    64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 2);
        run(OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        run(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run(OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
        run(OP_MULH,   -64'sd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run(OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        run(OP_DIV,    -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        run(OP_REM,    -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run(OP_DIVU,   64'd100, 64'd7, 64'd14, 66);
        run(OP_DIVU,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run(OP_REM,    64'd5, 64'd0, 64'd5, 1);
        run(OP_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run(OP_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run(OP_DIVW,   64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run(OP_REMUW,  64'h1_0000_0007, 64'd2, 64'd1, 34);
        run(OP_REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run(OP_DIVW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run(OP_DIVUW,  64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run(OP_REMUW,  64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1);

        // Flush in the middle of a divide.
        accept(OP_DIV, -64'sd20, 64'd3, 1'b0, 64'd0, 66, tgt);
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_stall_before", 64'(stall_o), 64'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_stall_after", 64'(stall_o), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        repeat (80) @(negedge clk_i);
        chk("flush_idle_stall", 64'(stall_o), 64'd0);

        // Reset in the middle of a divide, then a fresh multiply.
        accept(OP_DIV, 64'd100, 64'd7, 1'b0, 64'd0, 66, tgt);
        repeat (19) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_stall_before", 64'(stall_o), 64'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        run(OP_MUL, 64'd6, 64'd9, 64'd54, 2);

        // Random operands against the bench's own arithmetic.
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom};
            b = {32'h0, $urandom} | 64'h1;
            if (i[0]) b = -b;
            sa = a;
            sb = b;
            p  = {64'h0, a} * {64'h0, b};
            run(OP_DIV,   a, b, 64'(sa / sb), 66);
            run(OP_REM,   a, b, 64'(sa % sb), 66);
            run(OP_REMU,  a, b, a % b, 66);
            run(OP_MUL,   a, b, a * b, 2);
            run(OP_MULHU, a, b, p[127:64], 2);
        end

        repeat (5) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
